spine_input_arbiter: RTL and testbench

Round-robin arbiter that shares the single spine-router forwarding engine among the 11 spine input ports. It replaces fixed lowest-port-first scanning with a fair, registered one-hot grant. The grant is held until the forwarding engine signals completion or a hold timeout expires. It sits between the port input FIFOs' valid flags and the spine router FSM's packet-capture stage.

---
 rtl/spine_input_arbiter_if.sv | 28 ++
 rtl/spine_input_arbiter.sv | 117 +++++++++++
 tb/tb_spine_input_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/spine_input_arbiter_if.sv
// Request/grant bundle between the spine input FIFOs, the arbiter and the forwarding engine.
// Latency: none, wires only.
// Backpressure: the grant is held until done or a hold timeout; requesters simply keep req asserted.
interface spine_input_arbiter_if #(
  parameter int NUM_PORTS = 11,
  parameter int ID_W      = 4
);
  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] port_enable;
  logic                 done;
  logic [NUM_PORTS-1:0] grant;
  logic                 grant_valid;
  logic [ID_W-1:0]      grant_id;
  logic                 busy;
  logic                 timeout_err;

  // Requester / forwarding-engine side.
  modport master (
    output req, port_enable, done,
    input  grant, grant_valid, grant_id, busy, timeout_err
  );

  // Arbiter side.
  modport slave (
    input  req, port_enable, done,
    output grant, grant_valid, grant_id, busy, timeout_err
  );
endinterface

// File: rtl/spine_input_arbiter.sv
// Round-robin arbiter sharing the spine forwarding engine among the input ports.
// Latency: grant visible 1 cycle after the request is sampled in IDLE; RELEASE + IDLE cycles separate grants.
// Backpressure: grant held until done or MAX_HOLD cycles elapse, then forced release with timeout_err.
module spine_input_arbiter #(
  parameter int NUM_PORTS = 11,
  parameter int ID_W      = 4,
  parameter int MAX_HOLD  = 16,
  parameter int CNT_W     = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  spine_input_arbiter_if.slave   bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  logic [1:0]           state;
  logic [ID_W-1:0]      rr_ptr;
  logic [CNT_W-1:0]     hold_cnt;

  logic [NUM_PORTS-1:0] grant_q;
  logic                 grant_valid_q;
  logic [ID_W-1:0]      grant_id_q;
  logic                 timeout_q;

  logic [NUM_PORTS-1:0] eff_req;
  logic                 sel_found;
  logic [ID_W-1:0]      sel_idx;
  logic [ID_W:0]        pos;
  logic                 hold_expired;
  logic [ID_W-1:0]      next_ptr;

  // Disabled ports never take part in arbitration.
  assign eff_req = bus.req & bus.port_enable;

  // The last cycle a grant may be held without done.
  assign hold_expired = (hold_cnt == CNT_W'(MAX_HOLD - 1));

  // Pointer moves one past the granted port; grant_id is already index+1, so only
  // the last port needs an explicit wrap back to 0.
  assign next_ptr = (grant_id_q == ID_W'(NUM_PORTS)) ? '0 : grant_id_q;

  // Find the first requesting port at or after rr_ptr, wrapping past the last port.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    pos       = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      pos = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (pos >= (ID_W+1)'(NUM_PORTS)) begin
        pos = pos - (ID_W+1)'(NUM_PORTS);
      end
      if (!sel_found && eff_req[pos[ID_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = pos[ID_W-1:0];
      end
    end
  end

  // Arbitration FSM with registered grant outputs; timeout_err is a one-cycle pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      hold_cnt      <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      timeout_q     <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sel_found) begin
            grant_q       <= NUM_PORTS'(1) << sel_idx;
            grant_id_q    <= sel_idx + ID_W'(1);
            grant_valid_q <= 1'b1;
            hold_cnt      <= '0;
            state         <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Grant is frozen here; req/port_enable changes cannot shorten it.
          hold_cnt <= hold_cnt + CNT_W'(1);
          if (bus.done || hold_expired) begin
            state         <= ST_RELEASE;
            rr_ptr        <= next_ptr;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            // done in the same cycle as expiry counts as a normal completion.
            timeout_q     <= !bus.done;
          end
        end
        ST_RELEASE: begin
          // One guaranteed idle cycle so the forwarding engine settles.
          state <= ST_IDLE;
        end
        default: begin
          state         <= ST_IDLE;
          grant_q       <= '0;
          grant_valid_q <= 1'b0;
          grant_id_q    <= '0;
        end
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.timeout_err = timeout_q;
  assign bus.busy        = (state == ST_BUSY) || (state == ST_RELEASE);

endmodule

// File: tb/tb_spine_input_arbiter.sv
// Self-checking bench for spine_input_arbiter: directed scenarios plus random traffic.
// Latency: outputs compared 1 time unit after every rising edge against a transaction-level model.
// Backpressure: done pulses and port masks are driven randomly; every wait is cycle-bounded.
module tb_spine_input_arbiter;

  localparam int N  = 11;
  localparam int MH = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  spine_input_arbiter_if #(.NUM_PORTS(N), .ID_W(4)) bus ();

  spine_input_arbiter #(.NUM_PORTS(N), .ID_W(4), .MAX_HOLD(MH), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: which port (1..N, 0 = none) owns the engine, how long it has
  // held it, whether we are in the mandatory gap after a release, and the fairness pointer.
  int m_owner;
  int m_held;
  int m_ptr;
  bit m_gap;
  bit m_to;

  task automatic model_reset();
    m_owner = 0; m_held = 0; m_ptr = 0; m_gap = 0; m_to = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] eff;
    m_to = 0;
    if (m_owner != 0) begin
      if (bus.done || m_held == MH - 1) begin
        m_to    = !bus.done;
        m_ptr   = m_owner % N;
        m_owner = 0;
        m_gap   = 1;
      end else begin
        m_held++;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else begin
      eff = bus.req & bus.port_enable;
      for (int k = 0; k < N; k++) begin
        int p;
        p = (m_ptr + k) % N;
        if (m_owner == 0 && eff[p]) begin
          m_owner = p + 1;
          m_held  = 0;
        end
      end
    end
  endtask

  task automatic compare_outputs();
    logic [31:0] exp_grant;
    exp_grant = (m_owner != 0) ? (32'd1 << (m_owner - 1)) : 32'd0;
    check("grant",       32'(bus.grant),       exp_grant);
    check("grant_valid", 32'(bus.grant_valid), 32'(m_owner != 0));
    check("grant_id",    32'(bus.grant_id),    32'(m_owner));
    check("busy",        32'(bus.busy),        32'(m_owner != 0 || m_gap));
    check("timeout_err", 32'(bus.timeout_err), 32'(m_to));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_grant",   32'(bus.grant),       32'd0);
    check("rst_gvalid",  32'(bus.grant_valid), 32'd0);
    check("rst_gid",     32'(bus.grant_id),    32'd0);
    check("rst_busy",    32'(bus.busy),        32'd0);
    check("rst_timeout", 32'(bus.timeout_err), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_grant(output int id);
    id = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.grant_valid) begin
        id = int'(bus.grant_id);
        return;
      end
      tick();
    end
    check("wait_grant_timeout", 32'd1, 32'd0);
  endtask

  // Hold a grant for one extra cycle, then pulse done.
  task automatic finish_grant();
    tick();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
  endtask

  initial begin
    int id;
    int held;
    int to_cnt;
    int exp_ids[3];

    bus.req = '0;
    bus.port_enable = '1;
    bus.done = 1'b0;
    #2;

    // 1: single request, 1-cycle grant latency, done releases through RELEASE.
    do_reset();
    bus.req = 11'h001;
    tick();
    check("t1_gid", 32'(bus.grant_id), 32'd1);
    check("t1_grant", 32'(bus.grant), 32'h001);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.req = '0;
    check("t1_rel_grant", 32'(bus.grant), 32'd0);
    check("t1_rel_busy", 32'(bus.busy), 32'd1);
    tick();
    check("t1_idle_busy", 32'(bus.busy), 32'd0);

    // 2: all ports requesting rotate 1..11 and wrap to 1.
    do_reset();
    bus.req = 11'h7FF;
    for (int g = 0; g < 12; g++) begin
      wait_grant(id);
      check("t2_seq", 32'(id), 32'(g % N + 1));
      finish_grant();
    end

    // 3: ports 2 and 5 alternate.
    do_reset();
    bus.req = 11'h012;
    exp_ids = '{2, 5, 2};
    for (int g = 0; g < 3; g++) begin
      wait_grant(id);
      check("t3_seq", 32'(id), 32'(exp_ids[g]));
      finish_grant();
    end

    // 4: no done -> held exactly MAX_HOLD cycles, one timeout pulse, port 11 re-granted.
    do_reset();
    bus.req = 11'h400;
    wait_grant(id);
    check("t4_gid", 32'(id), 32'd11);
    held = 0;
    to_cnt = 0;
    for (int i = 0; i < MH + 2; i++) begin
      if (bus.grant_valid) held++;
      if (bus.timeout_err) to_cnt++;
      if (i == MH) check("t4_rr_ptr", 32'(dut.rr_ptr), 32'd0);
      tick();
    end
    check("t4_held", 32'(held), 32'(MH));
    check("t4_timeouts", 32'(to_cnt), 32'd1);
    check("t4_regrant", 32'(bus.grant_id), 32'd11);

    // 5: port 1 masked; done coincides with the last allowed hold cycle.
    do_reset();
    bus.port_enable = 11'h7FE;
    bus.req = 11'h003;
    wait_grant(id);
    check("t5_gid", 32'(id), 32'd2);
    repeat (MH - 1) tick();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    check("t5_no_timeout", 32'(bus.timeout_err), 32'd0);
    check("t5_released", 32'(bus.grant_valid), 32'd0);
    wait_grant(id);
    check("t5_gid2", 32'(id), 32'd2);
    finish_grant();

    // 6: reset while port 7 holds the grant, then full request restarts at port 1.
    do_reset();
    bus.port_enable = 11'h7FF;
    bus.req = 11'h040;
    wait_grant(id);
    check("t6_gid", 32'(id), 32'd7);
    tick();
    #2;
    bus.req = 11'h7FF;
    do_reset();
    wait_grant(id);
    check("t6_after_reset", 32'(id), 32'd1);
    finish_grant();

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bus.req = 11'($urandom);
      bus.port_enable = 11'($urandom | $urandom);
      bus.done = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 500) == 0) begin
        #2;
        do_reset();
      end else begin
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
